// File: rtl/bayer_mem_pkg.sv
// Shared constants and types for the colour-plane SRAM arbiter.
package bayer_mem_pkg;

  localparam int AW         = 14;
  localparam int DW         = 8;
  localparam int MEM_RD_LAT = 1;
  localparam int ARB_LAT    = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/bayer_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM.
// The stat_* signals only exist when BAYER_ARB_STATS_EN is defined.
interface bayer_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          m0_req;
  logic          m0_lock;
  logic          m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_lock;
  logic          m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

`ifdef BAYER_ARB_STATS_EN
  logic [15:0]   stat_gnt0;
  logic [15:0]   stat_gnt1;
  logic          stat_starve;

  modport slave (
    input  m0_req, m0_lock, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_wr, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_wr, mem_addr, mem_wdata, owner,
    output stat_gnt0, stat_gnt1, stat_starve
  );

  modport master (
    output m0_req, m0_lock, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_wr, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_wr, mem_addr, mem_wdata, owner,
    input  stat_gnt0, stat_gnt1, stat_starve
  );
`else
  modport slave (
    input  m0_req, m0_lock, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_wr, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_wr, mem_addr, mem_wdata, owner
  );

  modport master (
    output m0_req, m0_lock, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_wr, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_wr, mem_addr, mem_wdata, owner
  );
`endif

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; i_last = 1 means master 1 was served last.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_gnt0,
  output logic o_gnt1
);

  assign o_gnt0 = i_req0 && (!i_req1 || i_last);
  assign o_gnt1 = i_req1 && (!i_req0 || !i_last);

endmodule

// File: rtl/bayer_mem_arbiter.sv
// Round-robin arbiter with bounded lock in front of one colour-plane SRAM.
// Optional grant/starvation statistics are built when BAYER_ARB_STATS_EN is defined.
module bayer_mem_arbiter
  import bayer_mem_pkg::*;
#(
  parameter int AW       = 14,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8
) (
  input logic                clk,
  input logic                reset,
  bayer_mem_arbiter_if.slave bus
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  owner_e        r_owner;
  logic          r_last;
  logic [7:0]    r_hold_cnt;
  logic          r_mem_wr;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  rd_tag_t       r_tag [ARB_LAT];

  logic          w_rr_gnt0;
  logic          w_rr_gnt1;
  logic          w_cap;
  logic          w_lock0;
  logic          w_lock1;
  logic          w_cont0;
  logic          w_cont1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_grant;
  logic          w_sel_wr;
  logic          w_sel_lock;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_other_req;
  logic          w_override;
  rd_tag_t       w_tag_new;
  rd_tag_t       w_tag_out;

  rr_arb2 u_rr_arb2 (
    .i_req0 (bus.m0_req),
    .i_req1 (bus.m1_req),
    .i_last (r_last),
    .o_gnt0 (w_rr_gnt0),
    .o_gnt1 (w_rr_gnt1)
  );

  // A locked owner keeps the bus until the hold cap is hit; at the cap the
  // plain round-robin result applies, which hands the bus to the other side.
  assign w_cap   = (r_hold_cnt >= HOLD_LIMIT);
  assign w_lock0 = (r_owner == OWN_M0) && bus.m0_lock && bus.m0_req;
  assign w_lock1 = (r_owner == OWN_M1) && bus.m1_lock && bus.m1_req;
  assign w_cont0 = w_lock0 && !w_cap;
  assign w_cont1 = w_lock1 && !w_cap;

  assign w_gnt0  = w_cont0 || (!w_cont1 && w_rr_gnt0);
  assign w_gnt1  = w_cont1 || (!w_cont0 && w_rr_gnt1);
  assign w_grant = w_gnt0 || w_gnt1;

  assign w_sel_wr    = w_gnt1 ? bus.m1_wr    : bus.m0_wr;
  assign w_sel_lock  = w_gnt1 ? bus.m1_lock  : bus.m0_lock;
  assign w_sel_addr  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
  assign w_sel_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
  assign w_other_req = w_gnt1 ? bus.m0_req   : bus.m1_req;

  assign w_override = w_cap && ((w_lock0 && bus.m1_req) || (w_lock1 && bus.m0_req));

  assign w_tag_new = '{valid: w_grant && !w_sel_wr, id: w_gnt1};
  assign w_tag_out = r_tag[ARB_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_last      <= 1'b1;
      r_hold_cnt  <= 8'd0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int i = 0; i < ARB_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_owner     <= !w_sel_lock ? OWN_NONE : (w_gnt1 ? OWN_M1 : OWN_M0);
        r_last      <= w_gnt1;
        r_hold_cnt  <= ((w_cont0 || w_cont1) && w_other_req) ? r_hold_cnt + 8'd1 : 8'd0;
        r_mem_wr    <= w_sel_wr;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end else begin
        // Idle cycle also covers a locked owner dropping its request.
        r_owner    <= OWN_NONE;
        r_hold_cnt <= 8'd0;
        r_mem_wr   <= 1'b0;
      end
      r_tag[0] <= w_tag_new;
      for (int i = 1; i < ARB_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign bus.m0_gnt    = w_gnt0;
  assign bus.m1_gnt    = w_gnt1;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.owner     = r_owner;

  assign bus.m0_rvalid = w_tag_out.valid && !w_tag_out.id;
  assign bus.m1_rvalid = w_tag_out.valid && w_tag_out.id;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;

`ifdef BAYER_ARB_STATS_EN
  logic [15:0] r_stat_gnt0;
  logic [15:0] r_stat_gnt1;
  logic        r_stat_starve;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_gnt0   <= 16'd0;
      r_stat_gnt1   <= 16'd0;
      r_stat_starve <= 1'b0;
    end else begin
      if (w_gnt0 && (r_stat_gnt0 != 16'hFFFF)) r_stat_gnt0 <= r_stat_gnt0 + 16'd1;
      if (w_gnt1 && (r_stat_gnt1 != 16'hFFFF)) r_stat_gnt1 <= r_stat_gnt1 + 16'd1;
      if (w_override) r_stat_starve <= 1'b1;
    end
  end

  assign bus.stat_gnt0   = r_stat_gnt0;
  assign bus.stat_gnt1   = r_stat_gnt1;
  assign bus.stat_starve = r_stat_starve;
`endif

endmodule

// File: tb/tb_bayer_mem_arbiter.sv
// Directed vector bench for bayer_mem_arbiter (MAX_HOLD=4) with a small SRAM model.
module tb_bayer_mem_arbiter;

  localparam int NV = 33;

  // Command shorthands: {req, lock, wr}
  localparam logic [2:0] NO  = 3'b000;
  localparam logic [2:0] RD  = 3'b100;
  localparam logic [2:0] RDL = 3'b110;
  localparam logic [2:0] WR  = 3'b101;
  localparam logic [2:0] WRL = 3'b111;
  localparam logic [2:0] LK  = 3'b010;
  localparam logic [1:0] G0  = 2'b10;
  localparam logic [1:0] G1  = 2'b01;
  localparam logic [1:0] GN  = 2'b00;
  localparam logic [1:0] ON  = 2'd0;
  localparam logic [1:0] OM0 = 2'd1;
  localparam logic [7:0] Z8  = 8'h00;
  localparam logic [13:0] Z14 = 14'h0000;

  typedef struct {
    logic [2:0]  c0;
    logic [13:0] a0;
    logic [7:0]  d0;
    logic [2:0]  c1;
    logic [13:0] a1;
    logic [7:0]  d1;
    logic [44:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bayer_mem_arbiter_if #(.AW(14), .DW(8)) bus ();

  bayer_mem_arbiter #(.AW(14), .DW(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  ram [0:16383];
  logic [7:0]  ram_q;
  logic        pre_we;
  logic [13:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
    ram_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = ram_q;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] c0, input logic [13:0] a0, input logic [7:0] d0,
                              input logic [2:0] c1, input logic [13:0] a1, input logic [7:0] d1,
                              input logic [1:0] g, input logic [1:0] own, input logic mwr,
                              input logic [13:0] maddr, input logic [7:0] mwd,
                              input logic v0, input logic [7:0] rd0, input logic v1, input logic [7:0] rd1);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.d0 = d0;
    v.c1 = c1; v.a1 = a1; v.d1 = d1;
    v.exp = {g, own, mwr, maddr, mwd, v0, rd0, v1, rd1};
    return v;
  endfunction

  function automatic logic [44:0] snap();
    return {bus.m0_gnt, bus.m1_gnt, bus.owner, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
            bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, bus.m1_rdata};
  endfunction

  task automatic chk(input string name, input logic [44:0] got, input logic [44:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end else begin
      $display("%s: ok (%h)", name, got);
    end
  endtask

  task automatic drive(input logic [2:0] c0, input logic [13:0] a0, input logic [7:0] d0,
                       input logic [2:0] c1, input logic [13:0] a1, input logic [7:0] d1);
    {bus.m0_req, bus.m0_lock, bus.m0_wr} = c0;
    bus.m0_addr = a0;
    bus.m0_wdata = d0;
    {bus.m1_req, bus.m1_lock, bus.m1_wr} = c1;
    bus.m1_addr = a1;
    bus.m1_wdata = d1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
  endtask

  initial begin
    reset = 1'b1;
    pre_we = 1'b0;
    pre_addr = Z14;
    pre_data = Z8;
    drive(NO, Z14, Z8, NO, Z14, Z8);

    // Fair contention straight after reset: m0 first, then alternate.
    vecs[0]  = mk(RD,  14'h0010, Z8, RD, 14'h0020, Z8, G0, ON, 1'b0, 14'h0000, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[1]  = mk(RD,  14'h0010, Z8, RD, 14'h0020, Z8, G1, ON, 1'b0, 14'h0010, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[2]  = mk(RD,  14'h0010, Z8, RD, 14'h0020, Z8, G0, ON, 1'b0, 14'h0020, Z8, 1'b1, 8'h11, 1'b0, Z8);
    vecs[3]  = mk(RD,  14'h0010, Z8, RD, 14'h0020, Z8, G1, ON, 1'b0, 14'h0010, Z8, 1'b0, Z8, 1'b1, 8'h22);
    vecs[4]  = mk(RD,  14'h0010, Z8, RD, 14'h0020, Z8, G0, ON, 1'b0, 14'h0020, Z8, 1'b1, 8'h11, 1'b0, Z8);
    vecs[5]  = mk(RD,  14'h0010, Z8, RD, 14'h0020, Z8, G1, ON, 1'b0, 14'h0010, Z8, 1'b0, Z8, 1'b1, 8'h22);
    vecs[6]  = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0020, Z8, 1'b1, 8'h11, 1'b0, Z8);
    vecs[7]  = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0020, Z8, 1'b0, Z8, 1'b1, 8'h22);
    vecs[8]  = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0020, Z8, 1'b0, Z8, 1'b0, Z8);
    // Single read of 0x0081.
    vecs[9]  = mk(RD,  14'h0081, Z8, NO, Z14, Z8, G0, ON, 1'b0, 14'h0020, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[10] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0081, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[11] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0081, Z8, 1'b1, 8'h5A, 1'b0, Z8);
    vecs[12] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0081, Z8, 1'b0, Z8, 1'b0, Z8);
    // Write-then-read hazard on 0x1FFF.
    vecs[13] = mk(WR,  14'h1FFF, 8'h3C, NO, Z14, Z8, G0, ON, 1'b0, 14'h0081, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[14] = mk(NO,  Z14, Z8, RD, 14'h1FFF, Z8, G1, ON, 1'b1, 14'h1FFF, 8'h3C, 1'b0, Z8, 1'b0, Z8);
    vecs[15] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h1FFF, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[16] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h1FFF, Z8, 1'b0, Z8, 1'b1, 8'h3C);
    vecs[17] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h1FFF, Z8, 1'b0, Z8, 1'b0, Z8);
    // Locked neighbourhood burst against a waiting m1: 1 + 4 grants, then m1.
    vecs[18] = mk(RDL, 14'h0081, Z8, RD, 14'h0020, Z8, G0, ON,  1'b0, 14'h1FFF, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[19] = mk(RDL, 14'h0080, Z8, RD, 14'h0020, Z8, G0, OM0, 1'b0, 14'h0081, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[20] = mk(RDL, 14'h0082, Z8, RD, 14'h0020, Z8, G0, OM0, 1'b0, 14'h0080, Z8, 1'b1, 8'h5A, 1'b0, Z8);
    vecs[21] = mk(RDL, 14'h0001, Z8, RD, 14'h0020, Z8, G0, OM0, 1'b0, 14'h0082, Z8, 1'b1, 8'hA0, 1'b0, Z8);
    vecs[22] = mk(RDL, 14'h0101, Z8, RD, 14'h0020, Z8, G0, OM0, 1'b0, 14'h0001, Z8, 1'b1, 8'hA2, 1'b0, Z8);
    vecs[23] = mk(RDL, 14'h0101, Z8, RD, 14'h0020, Z8, G1, OM0, 1'b0, 14'h0101, Z8, 1'b1, 8'h01, 1'b0, Z8);
    vecs[24] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0020, Z8, 1'b1, 8'hB1, 1'b0, Z8);
    vecs[25] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0020, Z8, 1'b0, Z8, 1'b1, 8'h22);
    vecs[26] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0020, Z8, 1'b0, Z8, 1'b0, Z8);
    // Lock release: owner drops req, m1 granted in the same cycle.
    vecs[27] = mk(RDL, 14'h0080, Z8, NO, Z14, Z8, G0, ON,  1'b0, 14'h0020, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[28] = mk(RDL, 14'h0082, Z8, NO, Z14, Z8, G0, OM0, 1'b0, 14'h0080, Z8, 1'b0, Z8, 1'b0, Z8);
    vecs[29] = mk(LK,  Z14, Z8, RD, 14'h0010, Z8, G1, OM0, 1'b0, 14'h0082, Z8, 1'b1, 8'hA0, 1'b0, Z8);
    vecs[30] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0010, Z8, 1'b1, 8'hA2, 1'b0, Z8);
    vecs[31] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0010, Z8, 1'b0, Z8, 1'b1, 8'h11);
    vecs[32] = mk(NO,  Z14, Z8, NO, Z14, Z8, GN, ON, 1'b0, 14'h0010, Z8, 1'b0, Z8, 1'b0, Z8);

    preload(14'h0010, 8'h11);
    preload(14'h0020, 8'h22);
    preload(14'h0081, 8'h5A);
    preload(14'h0080, 8'hA0);
    preload(14'h0082, 8'hA2);
    preload(14'h0001, 8'h01);
    preload(14'h0101, 8'hB1);
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_state", snap(), 45'd0);
`ifdef BAYER_ARB_STATS_EN
    chk("reset_stats", 45'({bus.stat_gnt0, bus.stat_gnt1, bus.stat_starve}), 45'd0);
`endif

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].c0, vecs[i].a0, vecs[i].d0, vecs[i].c1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("vec%0d", i), snap(), vecs[i].exp);
      @(negedge clk);
    end

`ifdef BAYER_ARB_STATS_EN
    chk("stat_starve", 45'(bus.stat_starve), 45'd1);
    chk("stat_gnt0", 45'(bus.stat_gnt0), 45'd12);
    chk("stat_gnt1", 45'(bus.stat_gnt1), 45'd6);
`endif

    // Reset mid-burst: locked read, locked write, then reset just after the write is registered.
    drive(RDL, 14'h0081, Z8, NO, Z14, Z8);
    #1;
    chk("rst_rd_gnt", 45'({bus.m0_gnt, bus.m1_gnt}), 45'(G0));
    @(negedge clk);
    drive(WRL, 14'h0005, 8'h77, NO, Z14, Z8);
    #1;
    chk("rst_wr_gnt", 45'({bus.m0_gnt, bus.m1_gnt}), 45'(G0));
    @(posedge clk);
    #1;
    chk("rst_pre", 45'({bus.mem_wr, bus.owner, bus.m0_rvalid, bus.m0_rdata}), 45'({1'b1, OM0, 1'b1, 8'h5A}));
    reset = 1'b1;
    drive(NO, Z14, Z8, NO, Z14, Z8);
    #1;
    chk("rst_async", 45'({bus.mem_wr, bus.owner, bus.m0_rvalid, bus.m1_rvalid}), 45'd0);
`ifdef BAYER_ARB_STATS_EN
    chk("rst_starve_clr", 45'(bus.stat_starve), 45'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("post_rst_idle%0d", k), 45'({bus.m0_rvalid, bus.m1_rvalid, bus.mem_wr}), 45'd0);
      @(negedge clk);
    end
    drive(RD, 14'h0010, Z8, RD, 14'h0020, Z8);
    #1;
    chk("post_rst_tie", 45'({bus.m0_gnt, bus.m1_gnt}), 45'(G0));
    @(negedge clk);
    drive(NO, Z14, Z8, NO, Z14, Z8);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bayer_mem_arbiter.md
Name: bayer_mem_arbiter

Overview:
- Shares one single-port color-plane SRAM (128x128 pixels, 8 bit, 14-bit address) between two requesters. Master 0 is the demosaic engine; master 1 is the host loader/readout.
- Three instances sit in front of the R, G and B memories.
- Arbitration is round-robin with an optional lock. The lock lets the demosaic engine finish a neighbourhood read burst uninterrupted.
- Memory-side signals are registered, and read data is routed back to the issuer with a fixed latency.

Parameters:
- AW, 14, address width (row[13:7], col[6:0]).
- DW, 8, pixel data width.
- MAX_HOLD, 8, maximum consecutive locked grants to one master while the other is requesting; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 access request; its command is valid while high.
- m0_lock  in  1  master 0 asks to keep ownership after this grant.
- m0_wr  in  1  1 = write, 0 = read.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  combinational grant; the command is accepted this cycle.
- m0_rvalid  out  1  read data valid for master 0.
- m0_rdata  out  DW  read data for master 0.
- m1_req, m1_lock, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- mem_wr  out  1  SRAM write strobe.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data, valid one cycle after mem_addr.
- owner  out  2  current owner: 0 = none, 1 = m0, 2 = m1.

Behaviour:
- Reset values: all outputs 0; owner=NONE; last-served pointer = m1 (so m0 wins the first tie); hold_cnt=0; read-tag pipeline cleared.
- State owner ∈ {NONE, M0, M1}. At most one gnt is high per cycle. gnt=1 only when the matching req=1.
- Grant decision, evaluated every cycle:
  - Owner Mx with mx_lock=1, mx_req=1 and hold_cnt<MAX_HOLD: grant Mx only.
  - Otherwise with one requester: grant it.
  - Otherwise with both requesting: grant the master that was not last served.
  - Otherwise: no grant.
- On a grant to Mx:
  - owner <= Mx if mx_lock=1, else NONE.
  - last-served <= Mx.
  - hold_cnt increments if the grant was a locked continuation and the other master was requesting; otherwise hold_cnt <= 0.
- When hold_cnt reaches MAX_HOLD, the lock is ignored for one decision. The other master wins that decision if requesting, and hold_cnt <= 0.
- An owner that drops req while holding lock releases ownership: owner <= NONE.
- Latency:
  - Cycle N: grant.
  - Cycle N+1: mem_wr/mem_addr/mem_wdata registered from the granted command.
  - Cycle N+2: for a read, mx_rvalid=1 and mx_rdata=mem_rdata.
  - A write produces no rvalid.
  - With no grant, mem_wr <= 0 and mem_addr/mem_wdata hold their previous values.
- A 2-stage tag pipeline {valid, id} carries the issuer. Back-to-back grants sustain one access per cycle with no bubbles.
- Ordering: accesses execute in grant order. Master 0 writes address A at N, master 1 reads A at N+1: master 1 receives the new data.
- The rvalid/rdata outputs of the two masters are independent; both are 0 outside their valid cycle.
- Asynchronous reset mid-burst drops in-flight reads (no rvalid after reset) and forces mem_wr=0 immediately.

Optional Feature:
- Macro BAYER_ARB_STATS_EN.
- Defined: adds outputs stat_gnt0 and stat_gnt1 (16 bit each), saturating grant counters cleared by reset, and stat_starve (1 bit). stat_starve is sticky; it sets when a hold_cnt==MAX_HOLD override occurs.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package bayer_mem_pkg:
  - constants: AW=14, DW=8, MEM_RD_LAT=1, ARB_LAT=2.
  - owner enum: OWN_NONE/OWN_M0/OWN_M1.
  - read-tag struct {valid, id}.
- Sub-module rr_arb2: combinational 2-way round-robin pick (req0, req1, last) -> gnt0, gnt1. It is instanced once; lock/hold logic stays in the top module.

Test Plan:
- Single read: m0 reads addr 0x0081 while the RAM model holds 0x5A → m0_gnt same cycle; mem_addr=0x0081 at N+1; m0_rvalid=1, m0_rdata=0x5A at N+2; m1_rvalid stays 0.
- Fair contention: both masters request continuously, no lock, for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1 (m0 first after reset).
- Lock and starvation cap: MAX_HOLD=4, m0 locked reading 4 neighbours while m1 requests → after m0's initial grant, m0 gets 4 locked continuation grants (hold_cnt reaches 4), then m1 is granted; stat_starve=1 when the macro is defined.
- Write-then-read hazard: m0 writes 0x3C to 0x1FFF at N, m1 reads 0x1FFF at N+1 → m1_rdata=0x3C at N+3.
- Reset mid-burst: assert reset one cycle after a read grant → mem_wr=0 and owner=0 immediately; no rvalid seen after release; next grant goes to m0 on a tie.
- Lock release: m0 holds lock, then drops req → owner=0 next cycle; an m1 request is granted the same cycle m0_req falls.
